alu_muldiv_sequencer: RTL and testbench
=======================================

# alu_muldiv_sequencer

Multi-cycle sequencer for the multiply and divide operations selected by the ALU decoder's `ALU_Control` codes. The combinational ALU handles single-cycle ops; this block runs an iterative shift-add multiply and a restoring divide over `n` cycles. It drives a stall to the pipeline and returns the result with a done pulse. It sits beside the ALU in the execute stage. The `ALU_Control` code is sampled together with the operands.

## Interface
- `n`, default 32: operand and result width. Must be ≥ 2.
- `l`, default 4: width of `ALU_Control`.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request; sampled on the rising edge only when the block is idle.
- `ALU_Control`, in, `l`: op code. 4'b0101 = multiply, 4'b0110 = divide. Any other value is unsupported.
- `a`, in, `n`: operand A (multiplicand / dividend). Unsigned.
- `b`, in, `n`: operand B (multiplier / divisor). Unsigned.
- `busy`, out, 1: high in RUN and DONE.
- `stall`, out, 1: pipeline hold request (combinational).
- `done`, out, 1: one-cycle pulse; `result` is valid in this cycle.
- `result`, out, `n`: low `n` bits of the product, or the quotient. Registered.
- `div_by_zero`, out, 1: registered flag, valid with `done`.

## Operation
- **States:** IDLE, RUN, DONE. Encoded in 2 bits; the unused encoding goes to IDLE.
- **IDLE → RUN:** `start`=1 and a supported op. On that edge:
  - latch `a`, `b` and the op;
  - clear the accumulator/remainder;
  - set the iteration counter to `n`;
  - clear `div_by_zero`.
- **IDLE → DONE (divide by zero):** `start`=1, op is divide, `b`=0. On that edge:
  - `result` ← all ones;
  - `div_by_zero` ← 1.
- **Unsupported op with `start`=1:** ignored. State stays IDLE; no output changes.
- **Multiply, one RUN iteration:**
  - if the multiplier LSB is 1, accumulator += multiplicand (mod 2^n);
  - multiplicand <<= 1;
  - multiplier >>= 1.
  - After `n` iterations the accumulator holds product mod 2^n. Overflow bits are discarded; no flag is raised.
- **Divide, one RUN iteration (restoring):**
  - {rem, quo} <<= 1;
  - if rem ≥ divisor: rem −= divisor and quo[0] ← 1.
  - Internal rem is `n`+1 bits wide. Remainder is not exported.
- **Counter:** decrements once per RUN cycle. The edge on which it equals 1 moves the state to DONE and loads `result`.
- **DONE → IDLE:** unconditional on the next edge. `done`=1 only while in DONE.
- **Holding values:** `result` and `div_by_zero` hold until the next accepted `start` or reset.
- **`start` while busy:** ignored, including `start` during DONE. A new request can first be accepted in the first IDLE cycle.
- **Input changes after acceptance:** changes to `a`, `b`, `ALU_Control` have no effect on the operation in flight.
- **Reset values** (any time, including mid-RUN; the operation is abandoned):
  - state IDLE;
  - `busy`=0, `done`=0, `result`=0, `div_by_zero`=0;
  - counter=0;
  - internal registers=0.

## Timing
- Start accepted on edge E0.
  - RUN occupies the cycles after edges E0 … E(n−1).
  - DONE occupies the cycle after edge En; `done` is high for exactly that one cycle.
  - Latency from accepting edge to `done`: `n`+1 edges (33 for `n`=32).
- Divide by zero: DONE in the cycle after E0; `done` one edge after acceptance.
- `stall` = (IDLE & `start` & supported op) | RUN.
  - `stall` is low in DONE, so the pipeline advances and captures `result` in the `done` cycle.
  - `stall` is combinational from `start`/`ALU_Control` in IDLE only. It carries no combinational path from `a`/`b`.
- `busy`, `done`, `result`, `div_by_zero` are registered or decoded from state only.
- Back-to-back operation: `start` held high is accepted again one cycle after DONE, giving a period of `n`+2 cycles.

## Test plan
- **Multiply:** `n`=32, `a`=6, `b`=7, op 0101, `start` pulse.
  - `stall`=1 during request and RUN.
  - `done`=1 exactly 33 edges later, with `result`=42 and `div_by_zero`=0.
- **Divide:** `a`=100, `b`=7, op 0110.
  - `result`=14 on `done` at 33 edges.
  - Also `a`=0xFFFFFFFF, `b`=1 → `result`=0xFFFFFFFF.
- **Divide by zero:** `a`=5, `b`=0, op 0110.
  - `done` one edge after acceptance, with `result`=0xFFFFFFFF and `div_by_zero`=1.
  - Next multiply clears `div_by_zero`.
- **Overflow:** `a`=0x00010000, `b`=0x00010000, multiply → `result`=0.
  - Also `a`=0xFFFFFFFF, `b`=2 → `result`=0xFFFFFFFE.
- **Ignored requests:**
  - `start` with op 0011 → `busy`, `stall`, `done` stay 0 and `result` unchanged.
  - `start` held high with changing operands during RUN → first result unaffected; second op accepted the cycle after DONE.
- **Reset mid-operation:** assert `rst` asynchronously 10 cycles into RUN.
  - All outputs go to 0 immediately.
  - After release, a 3×3 multiply returns 9 with normal latency.

Source files
------------

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle sequencer for unsigned shift-add multiply and restoring divide.
// Holds the pipeline via stall while running; result is returned with a one-cycle done pulse.
module alu_muldiv_sequencer #(
    parameter int unsigned n = 32,
    parameter int unsigned l = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [l-1:0] ALU_Control,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [n-1:0] result,
    output logic         div_by_zero
);

    localparam int unsigned cw = $clog2(n + 1);
    localparam logic [l-1:0] op_mul = l'(5);
    localparam logic [l-1:0] op_div = l'(6);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic          op_div_q;
    logic [n-1:0]  x_q;    // multiplicand, or dividend shifting into quotient
    logic [n-1:0]  y_q;    // multiplier, or divisor
    logic [n-1:0]  acc_q;  // product accumulator, or partial remainder
    logic [cw-1:0] cnt_q;

    logic is_mul, is_div, accept, div_zero;

    assign is_mul   = (ALU_Control == op_mul);
    assign is_div   = (ALU_Control == op_div);
    assign accept   = (state_q == StIdle) && start && (is_mul || is_div);
    assign div_zero = accept && is_div && (b == '0);

    logic [n-1:0] mul_acc;
    logic [n:0]   rem_shift;
    logic [n-1:0] rem_diff, rem_next, quo_next;
    logic         rem_ge;

    always_comb begin
        mul_acc   = y_q[0] ? (acc_q + x_q) : acc_q;
        rem_shift = {acc_q, x_q[n-1]};
        rem_ge    = (rem_shift >= {1'b0, y_q});
        // Remainder is always below the divisor, so the subtraction fits in n bits.
        rem_diff  = rem_shift[n-1:0] - y_q;
        rem_next  = rem_ge ? rem_diff : rem_shift[n-1:0];
        quo_next  = {x_q[n-2:0], rem_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = div_zero ? StDone : StRun;
                end
            end
            StRun:   state_d = (cnt_q == cw'(1)) ? StDone : StRun;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        stall = 1'b0;
        case (state_q)
            StIdle: stall = start && (is_mul || is_div);
            StRun: begin
                busy  = 1'b1;
                stall = 1'b1;
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_div_q    <= is_div;
            x_q         <= a;
            y_q         <= b;
            acc_q       <= '0;
            cnt_q       <= div_zero ? '0 : cw'(n);
            div_by_zero <= div_zero;
            if (div_zero) begin
                result <= '1;
            end
        end else if (state_q == StRun) begin
            cnt_q <= cnt_q - cw'(1);
            if (op_div_q) begin
                acc_q <= rem_next;
                x_q   <= quo_next;
            end else begin
                acc_q <= mul_acc;
                x_q   <= x_q << 1;
                y_q   <= y_q >> 1;
            end
            if (cnt_q == cw'(1)) begin
                result <= op_div_q ? quo_next : mul_acc;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer: multiply, divide, divide-by-zero, overflow,
// ignored requests, back-to-back requests and asynchronous reset mid-run.
module tb_alu_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ALU_Control;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int vectors;
    int miscompares;
    int edges;

    alu_muldiv_sequencer #(
        .n(32),
        .l(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALU_Control (ALU_Control),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accepting edge (edge 1) up to the one that raises done.
    task automatic wait_done(input int limit);
        while (!done && edges < limit) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [3:0] iop, input logic [31:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        a           = ia;
        b           = ib;
        ALU_Control = iop;
        start       = 1'b1;
        #1;
        check({tag, " stall_req"}, stall, 1);
        tick();
        start = 1'b0;
        edges = 1;
        check({tag, " busy"}, busy, 1);
        if (exp_lat > 1) check({tag, " stall_run"}, stall, 1);
        wait_done(60);
        check({tag, " latency"}, edges, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " dbz"}, div_by_zero, exp_dbz);
        check({tag, " stall_done"}, stall, 0);
        tick();
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        ALU_Control = 4'b0000;
        a           = '0;
        b           = '0;
        #12;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst stall", stall, 0);
        check("rst result", result, 0);
        check("rst dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("mul 6x7", 32'd6, 32'd7, 4'b0101, 32'd42, 1'b0, 33);
        run_op("div 100/7", 32'd100, 32'd7, 4'b0110, 32'd14, 1'b0, 33);
        run_op("div max/1", 32'hFFFF_FFFF, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 33);
        run_op("div max/16", 32'hFFFF_FFFF, 32'd16, 4'b0110, 32'h0FFF_FFFF, 1'b0, 33);
        run_op("div 5/0", 32'd5, 32'd0, 4'b0110, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("mul ovf", 32'h0001_0000, 32'h0001_0000, 4'b0101, 32'd0, 1'b0, 33);
        run_op("mul max*2", 32'hFFFF_FFFF, 32'd2, 4'b0101, 32'hFFFF_FFFE, 1'b0, 33);

        // Unsupported op: nothing should move.
        a           = 32'd11;
        b           = 32'd13;
        ALU_Control = 4'b0011;
        start       = 1'b1;
        #1;
        check("unsup stall", stall, 0);
        tick();
        check("unsup busy", busy, 0);
        check("unsup done", done, 0);
        check("unsup result", result, 32'hFFFF_FFFE);
        start = 1'b0;
        tick();

        // start held high while operands change mid-run.
        a           = 32'd20;
        b           = 32'd3;
        ALU_Control = 4'b0101;
        start       = 1'b1;
        tick();
        edges = 1;
        a     = 32'd9;
        b     = 32'd9;
        wait_done(60);
        check("held latency1", edges, 33);
        check("held result1", result, 32'd60);
        check("held done_stall", stall, 0);
        tick();
        check("held idle_busy", busy, 0);
        check("held idle_stall", stall, 1);
        tick();
        edges = 1;
        start = 1'b0;
        check("held accept2", busy, 1);
        wait_done(60);
        check("held latency2", edges, 33);
        check("held result2", result, 32'd81);
        tick();

        // Asynchronous reset 10 cycles into a run.
        a           = 32'd7;
        b           = 32'd7;
        ALU_Control = 4'b0101;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst stall", stall, 0);
        check("arst result", result, 0);
        check("arst dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op("mul 3x3", 32'd3, 32'd3, 4'b0101, 32'd9, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
